// File: rtl/debug_pkg.sv
// Shared debugger constants: field widths and the serializer state encoding,
// also used by the decoder and the UART RX/TX glue.
package debug_pkg;

    localparam int DBG_CODE_W   = 8;
    localparam int DBG_RESULT_W = 32;
    localparam int DBG_SIZE_W   = 2;

    typedef enum logic [1:0] {
        DBG_IDLE = 2'b00,
        DBG_SEND = 2'b01,
        DBG_WAIT = 2'b10,
        DBG_DONE = 2'b11
    } dbg_state_e;

endpackage

// File: rtl/debugger_tx_serializer_if.sv
// Decoder-side request and UART TX-side handshake of the response serializer.
interface debugger_tx_serializer_if
    import debug_pkg::*;
#(
    parameter int DATA_W = DBG_RESULT_W,
    parameter int SIZE_W = DBG_SIZE_W
);

    logic              start;
    logic [DATA_W-1:0] result;
    logic [SIZE_W-1:0] size;
    logic              tx_done_tick;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              busy;
    logic              done;

    modport master (
        output start, result, size, tx_done_tick,
        input  tx_start, tx_data, busy, done
    );

    modport slave (
        input  start, result, size, tx_done_tick,
        output tx_start, tx_data, busy, done
    );

endinterface

// File: rtl/debugger_tx_serializer.sv
// Streams the selected bytes of a captured debug result, LSB first, to the
// UART transmitter, one byte per transmitter completion tick.
module debugger_tx_serializer
    import debug_pkg::*;
#(
    parameter int DATA_W = DBG_RESULT_W,
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    debugger_tx_serializer_if.slave  bus
);

    localparam int CNT_W = DBG_SIZE_W;

    dbg_state_e        state_q, state_d;
    logic [DATA_W-1:0] shreg_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  last_q;
    logic              lastByte;

    assign lastByte = (cnt_q == last_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            DBG_IDLE: if (bus.start) state_d = DBG_SEND;
            DBG_SEND: state_d = DBG_WAIT;
            DBG_WAIT: if (bus.tx_done_tick) state_d = lastByte ? DBG_DONE : DBG_SEND;
            DBG_DONE: state_d = DBG_IDLE;
            default:  state_d = DBG_IDLE;
        endcase
    end

    // The shift register is not shifted on the final tick, so tx_data keeps
    // showing the last byte sent until the next capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= DBG_IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                DBG_IDLE: begin
                    if (bus.start) begin
                        shreg_q <= bus.result;
                        last_q  <= bus.size;
                        cnt_q   <= '0;
                    end
                end
                DBG_WAIT: begin
                    if (bus.tx_done_tick && !lastByte) begin
                        cnt_q   <= cnt_q + 1'b1;
                        shreg_q <= {8'h00, shreg_q[DATA_W-1:8]};
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx_start = (state_q == DBG_SEND);
    assign bus.busy     = (state_q != DBG_IDLE);
    assign bus.done     = (state_q == DBG_DONE);
    assign bus.tx_data  = shreg_q[7:0];

endmodule

// File: tb/tb_debugger_tx_serializer.sv
// Randomized self-checking bench for debugger_tx_serializer against a
// queue-based byte-stream model, plus directed literal checks.
module tb_debugger_tx_serializer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    debugger_tx_serializer_if #(.DATA_W(32), .SIZE_W(2)) bus ();

    debugger_tx_serializer #(.DATA_W(32), .NBYTES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    bit         mActive   = 1'b0;
    bit         mSendNext = 1'b0;
    bit         mDoneNext = 1'b0;
    logic [7:0] mByte     = 8'h00;
    logic [7:0] mQ[$];

    int         txCount   = 0;
    int         doneCount = 0;
    logic [7:0] obs[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: the response is the queue of bytes still to go; each accepted
    // tick pops one, and the transfer ends one cycle after the queue empties.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mActive = 0; mSendNext = 0; mDoneNext = 0; mByte = 8'h00;
                mQ.delete();
            end else if (!mActive) begin
                if (bus.start === 1'b1) begin
                    mQ.delete();
                    for (int k = 0; k <= int'(bus.size); k++) mQ.push_back(bus.result[8*k +: 8]);
                    mByte = mQ[0];
                    mActive = 1;
                    mSendNext = 1;
                end
            end else if (mDoneNext) begin
                mDoneNext = 0;
                mActive = 0;
            end else if (mSendNext) begin
                mSendNext = 0;
            end else if (bus.tx_done_tick === 1'b1) begin
                void'(mQ.pop_front());
                if (mQ.size() == 0) mDoneNext = 1;
                else begin
                    mSendNext = 1;
                    mByte = mQ[0];
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            checkOutput("model tx_start", 32'(bus.tx_start), 32'(mSendNext));
            checkOutput("model busy",     32'(bus.busy),     32'(mActive));
            checkOutput("model done",     32'(bus.done),     32'(mDoneNext));
            checkOutput("model tx_data",  32'(bus.tx_data),  32'(mByte));
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.tx_start === 1'b1) begin
                txCount++;
                obs.push_back(bus.tx_data);
            end
            if (bus.done === 1'b1) doneCount++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [31:0] r, input logic [1:0] s);
        bus.start  = 1'b1;
        bus.result = r;
        bus.size   = s;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.result = $urandom;
        bus.size   = 2'($urandom_range(0, 3));
    endtask

    // Plays the UART TX side: answers each tx_start with a tick after gap cycles.
    task automatic serveBytes(input int nb, input int gap, input bit earlyTick, input bit midStart);
        for (int b = 0; b < nb; b++) begin
            int w = 0;
            while (bus.tx_start !== 1'b1 && w < 40) begin
                @(negedge clk);
                w++;
            end
            checkOutput("tx_start seen", 32'(bus.tx_start), 32'd1);
            if (bus.tx_start !== 1'b1) return;
            if (earlyTick) begin
                bus.tx_done_tick = 1'b1;
                @(negedge clk);
                bus.tx_done_tick = 1'b0;
                checkOutput("early tick ignored busy", 32'(bus.busy), 32'd1);
                checkOutput("early tick ignored done", 32'(bus.done), 32'd0);
            end
            if (midStart && b == 0) begin
                @(negedge clk);
                bus.start  = 1'b1;
                bus.result = 32'h12345678;
                bus.size   = 2'd3;
                @(negedge clk);
                bus.start  = 1'b0;
            end
            repeat (gap) @(negedge clk);
            bus.tx_done_tick = 1'b1;
            @(negedge clk);
            bus.tx_done_tick = 1'b0;
        end
    endtask

    task automatic waitIdle();
        int w = 0;
        while (bus.busy !== 1'b0 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checkOutput("return to idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic clearObs();
        obs.delete();
        txCount = 0;
        doneCount = 0;
    endtask

    initial begin
        logic [7:0] expDb[4];
        logic [31:0] r;
        logic [1:0]  s;
        int          dc;
        expDb = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};

        bus.start = 1'b0; bus.result = '0; bus.size = '0; bus.tx_done_tick = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        checkOutput("idle tx_start", 32'(bus.tx_start), 32'd0);
        checkOutput("idle tx_data",  32'(bus.tx_data),  32'h00);
        checkOutput("idle busy",     32'(bus.busy),     32'd0);
        checkOutput("idle done",     32'(bus.done),     32'd0);

        $display("[TB] four-byte DEADBEEF transfer");
        clearObs();
        applyStimulus(32'hDEADBEEF, 2'd3);
        serveBytes(4, 5, 1'b0, 1'b0);
        checkOutput("done after last tick", 32'(bus.done), 32'd1);
        waitIdle();
        checkOutput("deadbeef byte count", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4 && i < obs.size(); i++)
            checkOutput("deadbeef byte", 32'(obs[i]), 32'(expDb[i]));
        checkOutput("deadbeef tx_start pulses", 32'(txCount), 32'd4);
        checkOutput("deadbeef done pulses", 32'(doneCount), 32'd1);

        $display("[TB] single-byte transfer");
        clearObs();
        applyStimulus(32'h00000055, 2'd0);
        serveBytes(1, 3, 1'b0, 1'b0);
        checkOutput("single done after tick", 32'(bus.done), 32'd1);
        waitIdle();
        checkOutput("single byte count", 32'(obs.size()), 32'd1);
        if (obs.size() > 0) checkOutput("single byte", 32'(obs[0]), 32'h55);

        $display("[TB] start ignored while busy");
        clearObs();
        applyStimulus(32'h0000A1B2, 2'd1);
        serveBytes(2, 3, 1'b0, 1'b1);
        waitIdle();
        checkOutput("ignored start byte count", 32'(obs.size()), 32'd2);
        if (obs.size() >= 2) begin
            checkOutput("ignored start byte0", 32'(obs[0]), 32'hB2);
            checkOutput("ignored start byte1", 32'(obs[1]), 32'hA1);
        end
        checkOutput("ignored start done pulses", 32'(doneCount), 32'd1);
        clearObs();
        applyStimulus(32'h000000C3, 2'd0);
        serveBytes(1, 2, 1'b0, 1'b0);
        waitIdle();
        if (obs.size() > 0) checkOutput("restart byte", 32'(obs[0]), 32'hC3);

        $display("[TB] tick coinciding with tx_start");
        clearObs();
        applyStimulus(32'h00009A3C, 2'd1);
        serveBytes(2, 3, 1'b1, 1'b0);
        waitIdle();
        checkOutput("early tick byte count", 32'(obs.size()), 32'd2);

        $display("[TB] asynchronous reset mid-transfer");
        clearObs();
        applyStimulus(32'hCAFEF00D, 2'd3);
        serveBytes(1, 3, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        dc = doneCount;
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset tx_start", 32'(bus.tx_start), 32'd0);
        checkOutput("async reset busy",     32'(bus.busy),     32'd0);
        checkOutput("async reset done",     32'(bus.done),     32'd0);
        checkOutput("async reset tx_data",  32'(bus.tx_data),  32'h00);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("no done after reset", 32'(doneCount), 32'(dc));
        clearObs();
        applyStimulus(32'h00007E81, 2'd1);
        serveBytes(2, 4, 1'b0, 1'b0);
        waitIdle();
        checkOutput("post-reset byte count", 32'(obs.size()), 32'd2);
        if (obs.size() >= 2) begin
            checkOutput("post-reset byte0", 32'(obs[0]), 32'h81);
            checkOutput("post-reset byte1", 32'(obs[1]), 32'h7E);
        end

        $display("[TB] randomized transfers");
        for (int t = 0; t < 12; t++) begin
            r = $urandom;
            s = 2'($urandom_range(0, 3));
            clearObs();
            applyStimulus(r, s);
            serveBytes(int'(s) + 1, $urandom_range(1, 6), ($urandom_range(0, 3) == 0), 1'b0);
            checkOutput("random done", 32'(bus.done), 32'd1);
            waitIdle();
            checkOutput("random byte count", 32'(obs.size()), 32'(int'(s) + 1));
            for (int k = 0; k <= int'(s) && k < obs.size(); k++)
                checkOutput("random byte", 32'(obs[k]), 32'((r >> (8 * k)) & 32'hFF));
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
